prol16_mem_model: RTL and testbench
===================================

# prol16_mem_model

Parametrised, cycle-accurate memory responder for the PROL16 CPU memory bus: it answers the CPU's active-low chip-enable, output-enable and write-enable strobes with a configurable-latency read path and a word-addressed storage array. On top of the plain bus it adds:
- a backdoor preload port for program loading;
- a valid/ready write-trace FIFO for the scoreboard;
- sticky protocol-error flags;
- saturating access counters.

It sits on the testbench side of the CPU bus interface and generalises the fixed 16-bit, zero-check memory used so far.

## Interface
- DATA_WIDTH, 16, data and address bus width; matches gDataWidth.
- ADDR_WIDTH, 10, implemented depth is 2**ADDR_WIDTH words; must be ≤ DATA_WIDTH.
- READ_LATENCY, 1, cycles from read sample to data on mem_data_o; legal range 1..4.
- TRACE_DEPTH, 8, write-trace FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset (already decided): one clock; reset is synchronous and active-high.
- mem_addr_i  in  DATA_WIDTH  CPU word address.
- mem_data_i  in  DATA_WIDTH  CPU write data.
- mem_data_o  out  DATA_WIDTH  read data to the CPU.
- mem_ce_ni / mem_oe_ni / mem_we_ni  in  1 each  active-low strobes.
- load_en_i  in  1  backdoor write enable.
- load_addr_i  in  ADDR_WIDTH  backdoor address.
- load_data_i  in  DATA_WIDTH  backdoor data.
- trace_valid_o  out  1  trace entry available.
- trace_ready_i  in  1  consumer accepts the entry.
- trace_addr_o / trace_data_o  out  DATA_WIDTH each  head entry.
- trace_overflow_o  out  1  sticky: a trace entry was dropped.
- range_err_o  out  1  sticky: access above 2**ADDR_WIDTH-1.
- conflict_err_o  out  1  sticky: illegal strobe combination or load collision.
- rd_count_o / wr_count_o  out  32 each  accepted CPU reads and writes, saturating.

## Operation
- Strobes are sampled on every rising clk edge; ce_n=1 means idle.
- **Read** (ce_n=0, oe_n=0, we_n=1):
  - array word is captured and shifted through a READ_LATENCY-stage pipeline;
  - mem_data_o holds the last delivered word between reads;
  - rd_count increments.
- **Write** (ce_n=0, we_n=0, oe_n=1):
  - array is written at the sampling edge;
  - {addr, data} is pushed to the trace FIFO;
  - wr_count increments.
- **Conflict** (ce_n=0, oe_n=0, we_n=0):
  - no read, no write, no push, no count;
  - conflict_err_o is set.
- **Out of range** (upper DATA_WIDTH-ADDR_WIDTH address bits non-zero):
  - range_err_o is set;
  - a write is discarded (no trace, no count);
  - a read delivers all ones and still counts.
- **Backdoor load**: load_en_i=1 writes the array and is never traced or counted.
  - If it coincides with a CPU write, the load wins, the CPU write is dropped and conflict_err_o is set.
- **Read-after-write**: a write at edge N followed by a read of the same address at N+1 returns the new data.
- **Trace FIFO**:
  - entry transfers on valid&ready;
  - head is stable while valid&!ready;
  - push when full with no pop: entry dropped, trace_overflow_o set;
  - push and pop in the same cycle while full: both succeed, occupancy stays TRACE_DEPTH.
- Counters saturate at 32'hFFFF_FFFF; they do not wrap.
- Sticky flags clear only on rst.

## Timing
- rst sampled high causes, at that edge:
  - every output goes to 0 (mem_data_o=0, trace_valid_o=0, all flags 0, counters 0);
  - the FIFO and read pipeline are emptied;
  - in-flight reads are discarded.
- rst does not clear the array, so preloaded contents survive reset.
- Strobes and load_en_i are ignored while rst=1.
- Read latency: strobe sampled at edge N → mem_data_o valid after edge N+READ_LATENCY.
  - Back-to-back reads give one word per cycle.
- Trace: a write sampled at edge N gives trace_valid_o high after edge N+1 when the FIFO was empty.
  - FIFO head is registered, never combinational from the bus.
- Sticky flags and counters update at the edge where the causing access is sampled.

## Structure
- Package prol16_mem_pkg holds:
  - trace_entry_t struct {addr, data};
  - access_kind_t enum {ACC_IDLE, ACC_READ, ACC_WRITE, ACC_CONFLICT};
  - the strobe-decode function.
- One sub-module, prol16_trace_fifo: a synchronous FIFO parametrised on TRACE_DEPTH and trace_entry_t, with full/empty and the simultaneous push/pop rule.
- The read pipeline, array, counters and flags stay in prol16_mem_model.

## Test plan
- Preload 0x0005=0xBEEF via backdoor, pulse rst, CPU read 0x0005 with READ_LATENCY=2 → mem_data_o=0xBEEF two edges after the sample; rd_count_o=1.
- Write 0x0010=0x1234, then read 0x0010 on the next cycle → read returns 0x1234; trace gives {0x0010,0x1234}; wr_count_o=1.
- TRACE_DEPTH=8, trace_ready_i=0, 9 writes → 8 entries retained, trace_overflow_o=1; then 9 writes with ready=1 while full → occupancy stays 8, no further drops.
- Access address 0x0400 with ADDR_WIDTH=10 → range_err_o=1; a write is untraced; a read returns 0xFFFF.
- ce_n=oe_n=we_n=0, then load_en_i together with a CPU write to the same address → conflict_err_o=1 and the array holds load_data_i.
- Assert rst during a pending read → mem_data_o=0, counters 0, flags 0, and the pending data is never delivered.

Source files
------------

// File: rtl/prol16_mem_pkg.sv
// Shared types and strobe decoding for the PROL16 memory bus responder.
package prol16_mem_pkg;

    // Native PROL16 data width; the model itself is parametrised on top of this.
    localparam int GDATA_WIDTH = 16;

    typedef struct packed {
        logic [GDATA_WIDTH-1:0] addr;
        logic [GDATA_WIDTH-1:0] data;
    } trace_entry_t;

    typedef enum logic [1:0] {
        ACC_IDLE     = 2'd0,
        ACC_READ     = 2'd1,
        ACC_WRITE    = 2'd2,
        ACC_CONFLICT = 2'd3
    } access_kind_t;

    // Classify one sample of the active-low bus strobes.
    function automatic access_kind_t decode_strobes(input logic ce_n,
                                                    input logic oe_n,
                                                    input logic we_n);
        access_kind_t kind;
        kind = ACC_IDLE;
        if (ce_n == 1'b1) begin
            kind = ACC_IDLE;
        end else begin
            case ({oe_n, we_n})
                2'b01:   kind = ACC_READ;
                2'b10:   kind = ACC_WRITE;
                2'b00:   kind = ACC_CONFLICT;
                default: kind = ACC_IDLE;
            endcase
        end
        return kind;
    endfunction

endpackage

// File: rtl/prol16_trace_fifo.sv
// Synchronous write-trace FIFO; when full, a simultaneous push and pop both succeed.
module prol16_trace_fifo
    import prol16_mem_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter type entry_t = trace_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_entry,
    input  logic   pop,
    output entry_t head,
    output logic   valid,
    output logic   full
);

    localparam int              PW         = $clog2(DEPTH);
    localparam logic [PW:0]     FULL_COUNT = (PW+1)'(DEPTH);
    localparam logic [PW:0]     CNT_ZERO   = (PW+1)'(0);
    localparam logic [PW:0]     CNT_ONE    = (PW+1)'(1);
    localparam logic [PW-1:0]   PTR_ZERO   = PW'(0);
    localparam logic [PW-1:0]   PTR_ONE    = PW'(1);

    entry_t          store_r [DEPTH];
    logic [PW-1:0]   rd_ptr_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [PW:0]     count_r;
    logic            pop_s;
    logic            push_s;

    assign full  = (count_r == FULL_COUNT);
    assign valid = (count_r != CNT_ZERO);
    assign head  = store_r[rd_ptr_r];

    // Qualify requests: a pop frees a slot, so a full FIFO still accepts a push alongside it.
    always_comb begin
        pop_s  = pop & valid;
        push_s = push & (~full | pop_s);
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            store_r[wr_ptr_r] <= push_entry;
        end
    end

endmodule

// File: rtl/prol16_mem_model.sv
// Cycle-accurate PROL16 bus memory with backdoor load, write trace, error flags and counters.
module prol16_mem_model
    import prol16_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1,
    parameter int TRACE_DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic                  mem_ce_ni,
    input  logic                  mem_oe_ni,
    input  logic                  mem_we_ni,
    input  logic                  load_en_i,
    input  logic [ADDR_WIDTH-1:0] load_addr_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    output logic                  trace_valid_o,
    input  logic                  trace_ready_i,
    output logic [DATA_WIDTH-1:0] trace_addr_o,
    output logic [DATA_WIDTH-1:0] trace_data_o,
    output logic                  trace_overflow_o,
    output logic                  range_err_o,
    output logic                  conflict_err_o,
    output logic [31:0]           rd_count_o,
    output logic [31:0]           wr_count_o
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    localparam int DEPTH_WORDS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]   mem_r [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0]   pipe_data_r [READ_LATENCY];
    logic [READ_LATENCY-1:0] pipe_vld_r;

    access_kind_t            kind_s;
    logic                    oor_s;
    logic [ADDR_WIDTH-1:0]   idx_s;
    logic                    rd_s;
    logic                    wr_s;
    logic                    range_s;
    logic                    conflict_s;
    logic [DATA_WIDTH-1:0]   rd_word_s;

    logic                    push_r;
    entry_t                  push_entry_r;
    entry_t                  head_s;
    logic                    fifo_full_s;
    logic                    drop_s;

    // Decode the sampled strobes into accepted accesses and error causes.
    always_comb begin
        kind_s     = decode_strobes(mem_ce_ni, mem_oe_ni, mem_we_ni);
        oor_s      = ((mem_addr_i >> ADDR_WIDTH) != {DATA_WIDTH{1'b0}});
        idx_s      = mem_addr_i[ADDR_WIDTH-1:0];
        rd_s       = 1'b0;
        wr_s       = 1'b0;
        range_s    = 1'b0;
        conflict_s = 1'b0;
        if (kind_s == ACC_READ) begin
            rd_s    = 1'b1;
            range_s = oor_s;
        end else if (kind_s == ACC_WRITE) begin
            // The backdoor load owns the array this cycle, so the CPU write loses.
            wr_s       = ~oor_s & ~load_en_i;
            range_s    = oor_s;
            conflict_s = load_en_i;
        end else if (kind_s == ACC_CONFLICT) begin
            conflict_s = 1'b1;
        end else begin
            conflict_s = 1'b0;
        end
        rd_word_s = oor_s ? {DATA_WIDTH{1'b1}} : mem_r[idx_s];
    end

    // Storage array: backdoor load first, then accepted CPU writes; reset leaves contents intact.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (load_en_i) begin
                mem_r[load_addr_i] <= load_data_i;
            end else if (wr_s) begin
                mem_r[idx_s] <= mem_data_i;
            end
        end
    end

    // Read pipeline: capture at the sample edge, deliver READ_LATENCY edges later, hold between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_r <= {READ_LATENCY{1'b0}};
            mem_data_o <= {DATA_WIDTH{1'b0}};
        end else begin
            pipe_vld_r[0]  <= rd_s;
            pipe_data_r[0] <= rd_word_s;
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipe_vld_r[k]  <= pipe_vld_r[k-1];
                pipe_data_r[k] <= pipe_data_r[k-1];
            end
            if (pipe_vld_r[READ_LATENCY-1]) begin
                mem_data_o <= pipe_data_r[READ_LATENCY-1];
            end
        end
    end

    // Saturating access counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_o <= 32'd0;
            wr_count_o <= 32'd0;
        end else begin
            if (rd_s && (rd_count_o != 32'hFFFF_FFFF)) begin
                rd_count_o <= rd_count_o + 32'd1;
            end
            if (wr_s && (wr_count_o != 32'hFFFF_FFFF)) begin
                wr_count_o <= wr_count_o + 32'd1;
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            range_err_o      <= 1'b0;
            conflict_err_o   <= 1'b0;
            trace_overflow_o <= 1'b0;
        end else begin
            range_err_o      <= range_err_o | range_s;
            conflict_err_o   <= conflict_err_o | conflict_s;
            trace_overflow_o <= trace_overflow_o | drop_s;
        end
    end

    // Register the trace push so the FIFO never sees the bus combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            push_r <= 1'b0;
        end else begin
            push_r <= wr_s;
            if (wr_s) begin
                push_entry_r.addr <= mem_addr_i;
                push_entry_r.data <= mem_data_i;
            end
        end
    end

    // An entry is lost only when full and the head is not leaving in the same cycle.
    always_comb begin
        drop_s = push_r & fifo_full_s & ~(trace_ready_i & trace_valid_o);
    end

    prol16_trace_fifo #(
        .DEPTH   (TRACE_DEPTH),
        .entry_t (entry_t)
    ) u_trace_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_r),
        .push_entry (push_entry_r),
        .pop        (trace_ready_i),
        .head       (head_s),
        .valid      (trace_valid_o),
        .full       (fifo_full_s)
    );

    assign trace_addr_o = head_s.addr;
    assign trace_data_o = head_s.data;

endmodule

// File: tb/tb_prol16_mem_model.sv
// Directed self-checking bench for prol16_mem_model (READ_LATENCY=2, TRACE_DEPTH=8).
module tb_prol16_mem_model;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int RL = 2;
    localparam int TD = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          ce_n, oe_n, we_n;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          trace_valid, trace_ready;
    logic [DW-1:0] trace_addr, trace_data;
    logic          trace_ovf, range_err, conflict_err;
    logic [31:0]   rd_count, wr_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    prol16_mem_model #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .READ_LATENCY (RL),
        .TRACE_DEPTH  (TD)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_addr_i       (mem_addr),
        .mem_data_i       (mem_wdata),
        .mem_data_o       (mem_rdata),
        .mem_ce_ni        (ce_n),
        .mem_oe_ni        (oe_n),
        .mem_we_ni        (we_n),
        .load_en_i        (load_en),
        .load_addr_i      (load_addr),
        .load_data_i      (load_data),
        .trace_valid_o    (trace_valid),
        .trace_ready_i    (trace_ready),
        .trace_addr_o     (trace_addr),
        .trace_data_o     (trace_data),
        .trace_overflow_o (trace_ovf),
        .range_err_o      (range_err),
        .conflict_err_o   (conflict_err),
        .rd_count_o       (rd_count),
        .wr_count_o       (wr_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1; load_en = 1'b0;
    endtask

    task automatic cpu_read(input logic [DW-1:0] a);
        ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; mem_addr = a;
    endtask

    task automatic cpu_write(input logic [DW-1:0] a, input logic [DW-1:0] d);
        ce_n = 1'b0; oe_n = 1'b1; we_n = 1'b0; mem_addr = a; mem_wdata = d;
    endtask

    task automatic backdoor(input logic [AW-1:0] a, input logic [DW-1:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic test_reset();
        bus_idle(); trace_ready = 1'b0; mem_addr = 16'h0000; mem_wdata = 16'h0000;
        load_addr = 10'h000; load_data = 16'h0000;
        rst = 1'b1; tick(); rst = 1'b0;
        n_cmp++; if (mem_rdata !== 16'h0000) begin n_err++; $display("FAIL reset_rdata: got %h want 0000", mem_rdata); end
        n_cmp++; if ({trace_valid, trace_ovf, range_err, conflict_err} !== 4'b0000) begin n_err++;
            $display("FAIL reset_flags: got %b want 0000", {trace_valid, trace_ovf, range_err, conflict_err}); end
        n_cmp++; if ({rd_count, wr_count} !== 64'd0) begin n_err++; $display("FAIL reset_counts: got %0d/%0d want 0/0", rd_count, wr_count); end
    endtask

    task automatic test_preload_read();
        backdoor(10'h005, 16'hBEEF);
        rst = 1'b1; tick(); rst = 1'b0;
        cpu_read(16'h0005); tick(); bus_idle();
        n_cmp++; if (rd_count !== 32'd1) begin n_err++; $display("FAIL preload_rdcount: got %0d want 1", rd_count); end
        n_cmp++; if (mem_rdata !== 16'h0000) begin n_err++; $display("FAIL preload_lat0: got %h want 0000", mem_rdata); end
        tick();
        n_cmp++; if (mem_rdata !== 16'h0000) begin n_err++; $display("FAIL preload_lat1: got %h want 0000", mem_rdata); end
        tick();
        n_cmp++; if (mem_rdata !== 16'hBEEF) begin n_err++; $display("FAIL preload_data: got %h want BEEF", mem_rdata); end
    endtask

    task automatic test_read_after_write();
        cpu_write(16'h0010, 16'h1234); tick();
        cpu_read(16'h0010);
        n_cmp++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL raw_trace_early: got %b want 0", trace_valid); end
        n_cmp++; if (wr_count !== 32'd1) begin n_err++; $display("FAIL raw_wrcount: got %0d want 1", wr_count); end
        tick(); bus_idle();
        n_cmp++; if ({trace_valid, trace_addr, trace_data} !== {1'b1, 16'h0010, 16'h1234}) begin n_err++;
            $display("FAIL raw_trace: got %b %h %h want 1 0010 1234", trace_valid, trace_addr, trace_data); end
        tick();
        n_cmp++; if (mem_rdata !== 16'hBEEF) begin n_err++; $display("FAIL raw_hold: got %h want BEEF", mem_rdata); end
        tick();
        n_cmp++; if (mem_rdata !== 16'h1234) begin n_err++; $display("FAIL raw_data: got %h want 1234", mem_rdata); end
        n_cmp++; if (rd_count !== 32'd2) begin n_err++; $display("FAIL raw_rdcount: got %0d want 2", rd_count); end
        trace_ready = 1'b1; tick(); trace_ready = 1'b0;
        n_cmp++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL raw_trace_pop: got %b want 0", trace_valid); end
    endtask

    task automatic test_back_to_back();
        cpu_read(16'h0005); tick();
        cpu_read(16'h0010); tick();
        bus_idle(); tick();
        n_cmp++; if (mem_rdata !== 16'hBEEF) begin n_err++; $display("FAIL b2b_first: got %h want BEEF", mem_rdata); end
        tick();
        n_cmp++; if (mem_rdata !== 16'h1234) begin n_err++; $display("FAIL b2b_second: got %h want 1234", mem_rdata); end
        tick();
        n_cmp++; if (mem_rdata !== 16'h1234) begin n_err++; $display("FAIL b2b_hold: got %h want 1234", mem_rdata); end
        n_cmp++; if (rd_count !== 32'd4) begin n_err++; $display("FAIL b2b_rdcount: got %0d want 4", rd_count); end
    endtask

    task automatic test_trace_overflow();
        logic [DW-1:0] ea, ed;
        trace_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            cpu_write(16'h0100 + 16'(i), 16'hA000 + 16'(i)); tick();
        end
        bus_idle();
        n_cmp++; if (trace_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b want 0", trace_ovf); end
        tick();
        n_cmp++; if (trace_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", trace_ovf); end
        // Full FIFO: each cycle a new push lands while the head leaves.
        for (int i = 0; i < 10; i++) begin
            if (i < 9) cpu_write(16'h0200 + 16'(i), 16'hB000 + 16'(i));
            else bus_idle();
            trace_ready = (i >= 1);
            if (i >= 1) begin
                ea = (i - 1 < 8) ? 16'h0100 + 16'(i - 1) : 16'h0200;
                ed = (i - 1 < 8) ? 16'hA000 + 16'(i - 1) : 16'hB000;
                n_cmp++; if ({trace_valid, trace_addr, trace_data} !== {1'b1, ea, ed}) begin n_err++;
                    $display("FAIL ovf_pop%0d: got %b %h %h want 1 %h %h", i - 1, trace_valid, trace_addr, trace_data, ea, ed); end
            end
            tick();
        end
        bus_idle();
        for (int j = 0; j < 8; j++) begin
            ea = 16'h0201 + 16'(j);
            ed = 16'hB001 + 16'(j);
            n_cmp++; if ({trace_valid, trace_addr, trace_data} !== {1'b1, ea, ed}) begin n_err++;
                $display("FAIL ovf_drain%0d: got %b %h %h want 1 %h %h", j, trace_valid, trace_addr, trace_data, ea, ed); end
            tick();
        end
        trace_ready = 1'b0;
        n_cmp++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty: got %b want 0", trace_valid); end
        n_cmp++; if (wr_count !== 32'd19) begin n_err++; $display("FAIL ovf_wrcount: got %0d want 19", wr_count); end
    endtask

    task automatic test_range();
        backdoor(10'h000, 16'h0BAD);
        n_cmp++; if (range_err !== 1'b0) begin n_err++; $display("FAIL range_pre: got %b want 0", range_err); end
        cpu_write(16'h0400, 16'h5555); tick(); bus_idle();
        n_cmp++; if (range_err !== 1'b1) begin n_err++; $display("FAIL range_set: got %b want 1", range_err); end
        n_cmp++; if (wr_count !== 32'd19) begin n_err++; $display("FAIL range_wrcount: got %0d want 19", wr_count); end
        tick();
        n_cmp++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL range_trace: got %b want 0", trace_valid); end
        cpu_read(16'h0000); tick();
        cpu_read(16'h0400); tick();
        bus_idle(); tick();
        n_cmp++; if (mem_rdata !== 16'h0BAD) begin n_err++; $display("FAIL range_alias: got %h want 0BAD", mem_rdata); end
        tick();
        n_cmp++; if (mem_rdata !== 16'hFFFF) begin n_err++; $display("FAIL range_rdata: got %h want FFFF", mem_rdata); end
        n_cmp++; if (rd_count !== 32'd6) begin n_err++; $display("FAIL range_rdcount: got %0d want 6", rd_count); end
    endtask

    task automatic test_conflict();
        backdoor(10'h030, 16'h1111);
        n_cmp++; if (conflict_err !== 1'b0) begin n_err++; $display("FAIL conf_pre: got %b want 0", conflict_err); end
        ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b0; mem_addr = 16'h0030; mem_wdata = 16'h7777;
        tick(); bus_idle();
        n_cmp++; if (conflict_err !== 1'b1) begin n_err++; $display("FAIL conf_set: got %b want 1", conflict_err); end
        n_cmp++; if ({rd_count, wr_count} !== {32'd6, 32'd19}) begin n_err++; $display("FAIL conf_counts: got %0d/%0d want 6/19", rd_count, wr_count); end
        tick(); tick();
        n_cmp++; if ({trace_valid, mem_rdata} !== {1'b0, 16'hFFFF}) begin n_err++;
            $display("FAIL conf_noaccess: got %b %h want 0 FFFF", trace_valid, mem_rdata); end
        cpu_read(16'h0030); tick(); bus_idle(); tick(); tick();
        n_cmp++; if (mem_rdata !== 16'h1111) begin n_err++; $display("FAIL conf_nowrite: got %h want 1111", mem_rdata); end
        rst = 1'b1; tick(); rst = 1'b0;
        n_cmp++; if (conflict_err !== 1'b0) begin n_err++; $display("FAIL conf_clear: got %b want 0", conflict_err); end
        load_en = 1'b1; load_addr = 10'h031; load_data = 16'hCAFE;
        cpu_write(16'h0031, 16'hDEAD); tick(); bus_idle();
        n_cmp++; if ({conflict_err, wr_count} !== {1'b1, 32'd0}) begin n_err++;
            $display("FAIL load_collide: got %b %0d want 1 0", conflict_err, wr_count); end
        tick();
        n_cmp++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL load_notrace: got %b want 0", trace_valid); end
        cpu_read(16'h0031); tick(); bus_idle(); tick(); tick();
        n_cmp++; if (mem_rdata !== 16'hCAFE) begin n_err++; $display("FAIL load_wins: got %h want CAFE", mem_rdata); end
    endtask

    task automatic test_reset_pending();
        cpu_read(16'h0400); tick();
        n_cmp++; if ({rd_count, range_err} !== {32'd2, 1'b1}) begin n_err++;
            $display("FAIL pend_pre: got %0d %b want 2 1", rd_count, range_err); end
        rst = 1'b1; cpu_write(16'h0031, 16'h9999); tick();
        rst = 1'b0; bus_idle();
        n_cmp++; if (mem_rdata !== 16'h0000) begin n_err++; $display("FAIL pend_rdata: got %h want 0000", mem_rdata); end
        n_cmp++; if ({rd_count, wr_count} !== 64'd0) begin n_err++; $display("FAIL pend_counts: got %0d/%0d want 0/0", rd_count, wr_count); end
        n_cmp++; if ({trace_valid, trace_ovf, range_err, conflict_err} !== 4'b0000) begin n_err++;
            $display("FAIL pend_flags: got %b want 0000", {trace_valid, trace_ovf, range_err, conflict_err}); end
        tick(); tick(); tick();
        n_cmp++; if ({trace_valid, mem_rdata} !== {1'b0, 16'h0000}) begin n_err++;
            $display("FAIL pend_discard: got %b %h want 0 0000", trace_valid, mem_rdata); end
        cpu_read(16'h0031); tick(); bus_idle(); tick(); tick();
        n_cmp++; if (mem_rdata !== 16'hCAFE) begin n_err++; $display("FAIL pend_array: got %h want CAFE", mem_rdata); end
    endtask

    initial begin
        test_reset();
        test_preload_read();
        test_read_after_write();
        test_back_to_back();
        test_trace_overflow();
        test_range();
        test_conflict();
        test_reset_pending();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
